secded_counter: RTL and testbench

- Parametrised up/down counter whose state is held as Hamming SEC-DED codewords: per 4-bit nibble, 3 Hamming check bits plus 1 overall-parity bit.
- Every stored codeword is checked each cycle. Single-bit errors are scrubbed in place; double-bit errors freeze the counter in a HALT state.
- Successor to the nibble-Hamming counters in the fault-tolerant counter flow. Adds SEC-DED, up/down counting, load, error injection, and error statistics.

---
 rtl/secded_counter.sv | 180 ++++++++++++++++++
 tb/tb_secded_counter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/secded_counter.sv
// secded_counter: up/down counter whose state lives in per-nibble Hamming SEC-DED
// codewords; single-bit upsets are scrubbed in place, double-bit upsets halt the counter.
module secded_counter #(
    parameter  int unsigned WIDTH     = 16,
    parameter  int unsigned ERR_CNT_W = 8,
    localparam int unsigned BLOCKS    = WIDTH / 4,
    localparam int unsigned CHK_W     = 4 * BLOCKS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 up,
    input  logic                 load,
    input  logic [WIDTH-1:0]     load_value,
    input  logic                 inj_valid,
    input  logic [WIDTH-1:0]     inj_data_mask,
    input  logic [CHK_W-1:0]     inj_chk_mask,
    input  logic                 clear_err,
    output logic [WIDTH-1:0]     count,
    output logic                 count_valid,
    output logic                 sec_event,
    output logic [BLOCKS-1:0]    sec_blocks,
    output logic                 ded_event,
    output logic                 ded_sticky,
    output logic [ERR_CNT_W-1:0] corr_count
);

    typedef enum logic [0:0] {
        ST_RUN,
        ST_HALT
    } state_t;

    typedef enum logic [1:0] {
        CHK_HOLD,
        CHK_INJ,
        CHK_ENC
    } chk_sel_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     data_q, data_d, corr_data;
    logic [CHK_W-1:0]     chk_q, chk_d, chk_enc;
    chk_sel_t             chk_sel;
    logic [BLOCKS-1:0]    blk_sec, blk_ded, blk_err;
    logic                 sec_d, ded_d;
    logic [BLOCKS-1:0]    sec_blocks_d;
    logic [ERR_CNT_W-1:0] corr_d;

    function automatic logic [2:0] ham_p(input logic [3:0] d);
        ham_p = {d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3], d[0] ^ d[1] ^ d[2]};
    endfunction

    function automatic logic [3:0] encode(input logic [3:0] d);
        logic [2:0] p;
        p      = ham_p(d);
        encode = {^{d, p}, p};
    endfunction

    // Per-block check of the stored codeword, corrected nibble, and re-encode of next data.
    for (genvar i = 0; i < BLOCKS; i++) begin : g_blk
        logic [3:0] d, c, flip;
        logic [2:0] syn;
        logic       ovr;

        assign d   = data_q[4*i +: 4];
        assign c   = chk_q[4*i +: 4];
        assign syn = c[2:0] ^ ham_p(d);
        assign ovr = ^{d, c};

        always_comb begin
            flip = 4'b0000;
            case (syn)
                3'b111:  flip = 4'b0001;
                3'b011:  flip = 4'b0010;
                3'b101:  flip = 4'b0100;
                3'b110:  flip = 4'b1000;
                default: flip = 4'b0000;
            endcase
        end

        assign blk_sec[i]          = ovr;
        assign blk_ded[i]          = !ovr && (syn != 3'b000);
        assign blk_err[i]          = ovr || (syn != 3'b000);
        assign corr_data[4*i +: 4] = ovr ? (d ^ flip) : d;
        assign chk_enc[4*i +: 4]   = encode(data_d[4*i +: 4]);
    end

    // Next-state and datapath control, highest priority first.
    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        chk_sel      = CHK_HOLD;
        sec_d        = 1'b0;
        sec_blocks_d = '0;
        ded_d        = 1'b0;
        corr_d       = corr_count;
        case (state_q)
            ST_RUN: begin
                if (inj_valid) begin
                    data_d  = data_q ^ inj_data_mask;
                    chk_sel = CHK_INJ;
                end else if (load) begin
                    data_d  = load_value;
                    chk_sel = CHK_ENC;
                end else if (|blk_ded) begin
                    state_d = ST_HALT;
                    ded_d   = 1'b1;
                end else if (|blk_sec) begin
                    data_d       = corr_data;
                    chk_sel      = CHK_ENC;
                    sec_d        = 1'b1;
                    sec_blocks_d = blk_sec;
                    if (corr_count != '1) begin
                        corr_d = corr_count + ERR_CNT_W'(1);
                    end
                end else if (enable) begin
                    data_d  = up ? (data_q + WIDTH'(1)) : (data_q - WIDTH'(1));
                    chk_sel = CHK_ENC;
                end
            end
            ST_HALT: begin
                if (inj_valid) begin
                    data_d  = data_q ^ inj_data_mask;
                    chk_sel = CHK_INJ;
                end else if (load) begin
                    data_d  = load_value;
                    chk_sel = CHK_ENC;
                    state_d = ST_RUN;
                end else if (clear_err) begin
                    chk_sel = CHK_ENC;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
        if (clear_err) begin
            corr_d = '0;
        end
    end

    always_comb begin
        chk_d = chk_q;
        case (chk_sel)
            CHK_INJ: chk_d = chk_q ^ inj_chk_mask;
            CHK_ENC: chk_d = chk_enc;
            default: chk_d = chk_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q     <= '0;
            chk_q      <= '0;
            sec_event  <= 1'b0;
            sec_blocks <= '0;
            ded_event  <= 1'b0;
            ded_sticky <= 1'b0;
            corr_count <= '0;
        end else begin
            data_q     <= data_d;
            chk_q      <= chk_d;
            sec_event  <= sec_d;
            sec_blocks <= sec_blocks_d;
            ded_event  <= ded_d;
            ded_sticky <= (state_d == ST_HALT);
            corr_count <= corr_d;
        end
    end

    assign count       = data_q;
    assign count_valid = (state_q == ST_RUN) && (blk_err == '0);

endmodule

// File: tb/tb_secded_counter.sv
// tb_secded_counter: directed vector table, corner sequences, and randomized run against
// a flip-tracking model; two instances differ only in correction-counter width.
module tb_secded_counter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0, up = 1'b0, load = 1'b0, inj_valid = 1'b0, clear_err = 1'b0;
    logic [15:0] load_value = '0, inj_data_mask = '0, inj_chk_mask = '0;

    logic [15:0] count_a, count_b;
    logic        count_valid_a, count_valid_b, sec_event_a, sec_event_b;
    logic [3:0]  sec_blocks_a, sec_blocks_b;
    logic        ded_event_a, ded_event_b, ded_sticky_a, ded_sticky_b;
    logic [7:0]  corr_count_a;
    logic [1:0]  corr_count_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    secded_counter #(.WIDTH(16), .ERR_CNT_W(8)) u_dut_a (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(load_value), .inj_valid(inj_valid), .inj_data_mask(inj_data_mask),
        .inj_chk_mask(inj_chk_mask), .clear_err(clear_err), .count(count_a),
        .count_valid(count_valid_a), .sec_event(sec_event_a), .sec_blocks(sec_blocks_a),
        .ded_event(ded_event_a), .ded_sticky(ded_sticky_a), .corr_count(corr_count_a)
    );

    secded_counter #(.WIDTH(16), .ERR_CNT_W(2)) u_dut_b (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(load_value), .inj_valid(inj_valid), .inj_data_mask(inj_data_mask),
        .inj_chk_mask(inj_chk_mask), .clear_err(clear_err), .count(count_b),
        .count_valid(count_valid_b), .sec_event(sec_event_b), .sec_blocks(sec_blocks_b),
        .ded_event(ded_event_b), .ded_sticky(ded_sticky_b), .corr_count(corr_count_b)
    );

    typedef struct {
        logic        ld;
        logic [15:0] lv;
        logic        en;
        logic        up;
        logic        inj;
        logic [15:0] dm;
        logic [15:0] cm;
        logic        clr;
        logic [15:0] e_cnt;
        logic        e_val;
        logic        e_sec;
        logic [3:0]  e_blk;
        logic        e_ded;
        logic        e_stk;
        int          e_corr;
    } vec_t;

    vec_t tbl[$];

    // Behavioural model: true value plus the set of bits currently flipped in storage.
    logic [15:0] m_gold, m_df, m_cf;
    logic        m_halt, m_sec, m_ded;
    logic [3:0]  m_blk;
    int          m_c8, m_c2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] e_cnt, input logic e_val,
                             input logic e_sec, input logic [3:0] e_blk, input logic e_ded,
                             input logic e_stk, input int e_c8, input int e_c2);
        check({tag, ".count_a"}, 64'(count_a), 64'(e_cnt));
        check({tag, ".count_b"}, 64'(count_b), 64'(e_cnt));
        check({tag, ".valid_a"}, 64'(count_valid_a), 64'(e_val));
        check({tag, ".valid_b"}, 64'(count_valid_b), 64'(e_val));
        check({tag, ".sec_a"}, 64'(sec_event_a), 64'(e_sec));
        check({tag, ".sec_b"}, 64'(sec_event_b), 64'(e_sec));
        check({tag, ".blk_a"}, 64'(sec_blocks_a), 64'(e_blk));
        check({tag, ".blk_b"}, 64'(sec_blocks_b), 64'(e_blk));
        check({tag, ".ded_a"}, 64'(ded_event_a), 64'(e_ded));
        check({tag, ".ded_b"}, 64'(ded_event_b), 64'(e_ded));
        check({tag, ".sticky_a"}, 64'(ded_sticky_a), 64'(e_stk));
        check({tag, ".sticky_b"}, 64'(ded_sticky_b), 64'(e_stk));
        check({tag, ".corr_a"}, 64'(corr_count_a), 64'(e_c8));
        check({tag, ".corr_b"}, 64'(corr_count_b), 64'(e_c2));
    endtask

    task automatic apply(input logic ld, input logic [15:0] lv, input logic en, input logic u,
                         input logic inj, input logic [15:0] dm, input logic [15:0] cm,
                         input logic clr);
        load = ld; load_value = lv; enable = en; up = u;
        inj_valid = inj; inj_data_mask = dm; inj_chk_mask = cm; clear_err = clr;
    endtask

    task automatic idle();
        apply(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic row(input logic ld, input logic [15:0] lv, input logic en, input logic u,
                       input logic inj, input logic [15:0] dm, input logic [15:0] cm,
                       input logic clr, input logic [15:0] e_cnt, input logic e_val,
                       input logic e_sec, input logic [3:0] e_blk, input logic e_ded,
                       input logic e_stk, input int e_corr);
        vec_t v;
        v.ld = ld; v.lv = lv; v.en = en; v.up = u; v.inj = inj; v.dm = dm; v.cm = cm;
        v.clr = clr; v.e_cnt = e_cnt; v.e_val = e_val; v.e_sec = e_sec; v.e_blk = e_blk;
        v.e_ded = e_ded; v.e_stk = e_stk; v.e_corr = e_corr;
        tbl.push_back(v);
    endtask

    function automatic int blk_pop(input logic [15:0] df, input logic [15:0] cf, input int b);
        return $countones((df >> (4 * b)) & 16'hF) + $countones((cf >> (4 * b)) & 16'hF);
    endfunction

    task automatic model_reset();
        m_gold = '0; m_df = '0; m_cf = '0; m_halt = 1'b0;
        m_sec = 1'b0; m_ded = 1'b0; m_blk = '0; m_c8 = 0; m_c2 = 0;
    endtask

    task automatic model_step(input logic ld, input logic [15:0] lv, input logic en,
                              input logic u, input logic inj, input logic [15:0] dm,
                              input logic [15:0] cm, input logic clr);
        logic       any_ded;
        logic [3:0] secb;
        any_ded = 1'b0;
        secb    = '0;
        for (int b = 0; b < 4; b++) begin
            if (blk_pop(m_df, m_cf, b) >= 2) any_ded = 1'b1;
            if (blk_pop(m_df, m_cf, b) == 1) secb = secb | (4'(1) << b);
        end
        m_sec = 1'b0; m_ded = 1'b0; m_blk = '0;
        if (inj) begin
            m_df = m_df ^ dm;
            m_cf = m_cf ^ cm;
        end else if (ld) begin
            m_gold = lv; m_df = '0; m_cf = '0; m_halt = 1'b0;
        end else if (m_halt) begin
            if (clr) begin
                m_gold = m_gold ^ m_df; m_df = '0; m_cf = '0; m_halt = 1'b0;
            end
        end else if (any_ded) begin
            m_halt = 1'b1;
            m_ded  = 1'b1;
        end else if (secb != 4'b0) begin
            m_sec = 1'b1;
            m_blk = secb;
            m_df  = '0;
            m_cf  = '0;
            m_c8  = (m_c8 < 255) ? m_c8 + 1 : 255;
            m_c2  = (m_c2 < 3) ? m_c2 + 1 : 3;
        end else if (en) begin
            m_gold = u ? m_gold + 16'd1 : m_gold - 16'd1;
        end
        if (clr) begin
            m_c8 = 0;
            m_c2 = 0;
        end
    endtask

    task automatic gen_masks(output logic [15:0] dm, output logic [15:0] cm);
        int b1, b2, k1, k2;
        dm = '0;
        cm = '0;
        b1 = int'($urandom_range(3));
        k1 = int'($urandom_range(7));
        if (k1 < 4) dm = dm ^ (16'(1) << (4 * b1 + k1));
        else        cm = cm ^ (16'(1) << (4 * b1 + k1 - 4));
        if ($urandom_range(1) == 1) begin
            b2 = ($urandom_range(1) == 1) ? b1 : int'($urandom_range(3));
            k2 = int'($urandom_range(7));
            if (k2 < 4) dm = dm ^ (16'(1) << (4 * b2 + k2));
            else        cm = cm ^ (16'(1) << (4 * b2 + k2 - 4));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        r_ld, r_en, r_up, r_inj, r_clr, ok;
        logic [15:0] r_lv, r_dm, r_cm;

        // Directed table: counting, wrap-around, scrub latency, check-bit faults, halt and reload.
        row(1, 16'h00FF, 0, 0, 0, 16'h0, 16'h0, 0, 16'h00FF, 1, 0, 4'h0, 0, 0, 0);
        row(0, 16'h0, 1, 1, 0, 16'h0, 16'h0, 0, 16'h0100, 1, 0, 4'h0, 0, 0, 0);
        row(0, 16'h0, 1, 1, 0, 16'h0, 16'h0, 0, 16'h0101, 1, 0, 4'h0, 0, 0, 0);
        row(0, 16'h0, 1, 1, 0, 16'h0, 16'h0, 0, 16'h0102, 1, 0, 4'h0, 0, 0, 0);
        row(0, 16'h0, 1, 0, 0, 16'h0, 16'h0, 0, 16'h0101, 1, 0, 4'h0, 0, 0, 0);
        row(0, 16'h0, 1, 0, 0, 16'h0, 16'h0, 0, 16'h0100, 1, 0, 4'h0, 0, 0, 0);
        row(1, 16'hFFFF, 0, 0, 0, 16'h0, 16'h0, 0, 16'hFFFF, 1, 0, 4'h0, 0, 0, 0);
        row(0, 16'h0, 1, 1, 0, 16'h0, 16'h0, 0, 16'h0000, 1, 0, 4'h0, 0, 0, 0);
        row(0, 16'h0, 1, 0, 0, 16'h0, 16'h0, 0, 16'hFFFF, 1, 0, 4'h0, 0, 0, 0);
        row(1, 16'h1234, 0, 0, 0, 16'h0, 16'h0, 0, 16'h1234, 1, 0, 4'h0, 0, 0, 0);
        row(0, 16'h0, 1, 1, 1, 16'h0020, 16'h0, 0, 16'h1214, 0, 0, 4'h0, 0, 0, 0);
        row(0, 16'h0, 1, 1, 0, 16'h0, 16'h0, 0, 16'h1234, 1, 1, 4'h2, 0, 0, 1);
        row(0, 16'h0, 1, 1, 0, 16'h0, 16'h0, 0, 16'h1235, 1, 0, 4'h0, 0, 0, 1);
        row(0, 16'h0, 0, 0, 1, 16'h0, 16'h0008, 0, 16'h1235, 0, 0, 4'h0, 0, 0, 1);
        row(0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h1235, 1, 1, 4'h1, 0, 0, 2);
        row(0, 16'h0, 0, 0, 1, 16'h0, 16'h0010, 0, 16'h1235, 0, 0, 4'h0, 0, 0, 2);
        row(0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h1235, 1, 1, 4'h2, 0, 0, 3);
        row(1, 16'h0040, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0040, 1, 0, 4'h0, 0, 0, 3);
        row(0, 16'h0, 1, 1, 1, 16'h0003, 16'h0, 0, 16'h0043, 0, 0, 4'h0, 0, 0, 3);
        row(0, 16'h0, 1, 1, 0, 16'h0, 16'h0, 0, 16'h0043, 0, 0, 4'h0, 1, 1, 3);
        row(0, 16'h0, 1, 1, 0, 16'h0, 16'h0, 0, 16'h0043, 0, 0, 4'h0, 0, 1, 3);
        row(1, 16'hABCD, 0, 0, 0, 16'h0, 16'h0, 0, 16'hABCD, 1, 0, 4'h0, 0, 0, 3);
        row(0, 16'h0, 1, 1, 0, 16'h0, 16'h0, 0, 16'hABCE, 1, 0, 4'h0, 0, 0, 3);
        row(0, 16'h0, 1, 1, 0, 16'h0, 16'h0, 1, 16'hABCF, 1, 0, 4'h0, 0, 0, 0);

        idle();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset_held", 16'h0, 1, 0, 4'h0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all("reset_rel", 16'h0, 1, 0, 4'h0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            apply(tbl[i].ld, tbl[i].lv, tbl[i].en, tbl[i].up, tbl[i].inj, tbl[i].dm,
                  tbl[i].cm, tbl[i].clr);
            step();
            check_all($sformatf("row%0d", i), tbl[i].e_cnt, tbl[i].e_val, tbl[i].e_sec,
                      tbl[i].e_blk, tbl[i].e_ded, tbl[i].e_stk, tbl[i].e_corr,
                      (tbl[i].e_corr > 3) ? 3 : tbl[i].e_corr);
        end

        // Saturation: five corrections, the 2-bit counter sticks at 3.
        for (int k = 1; k <= 5; k++) begin
            apply(0, 16'h0, 0, 0, 1, 16'(1) << k, 16'h0, 0);
            step();
            check(.name($sformatf("sat%0d.valid", k)), .act(64'(count_valid_a)), .exp(64'(0)));
            idle();
            step();
            check_all($sformatf("sat%0d", k), 16'hABCF, 1, 1, (k < 4) ? 4'h1 : 4'h2, 0, 0,
                      k, (k > 3) ? 3 : k);
        end
        // Clear coinciding with a correction: correction happens, count clears.
        apply(0, 16'h0, 0, 0, 1, 16'h0100, 16'h0, 0);
        step();
        apply(0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 1);
        step();
        check_all("clr_sec", 16'hABCF, 1, 1, 4'h4, 0, 0, 0, 0);

        // Double fault, leave HALT with clear_err (raw data re-encoded).
        apply(0, 16'h0, 1, 1, 1, 16'h0300, 16'h0, 0);
        step();
        check_all("ded2_inj", 16'hA8CF, 0, 0, 4'h0, 0, 0, 0, 0);
        apply(0, 16'h0, 1, 1, 0, 16'h0, 16'h0, 0);
        step();
        check_all("ded2_halt", 16'hA8CF, 0, 0, 4'h0, 1, 1, 0, 0);
        apply(0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 1);
        step();
        check_all("halt_clr", 16'hA8CF, 1, 0, 4'h0, 0, 0, 0, 0);
        idle();
        step();
        check_all("halt_clr_idle", 16'hA8CF, 1, 0, 4'h0, 0, 0, 0, 0);

        // Reset asserted mid-cycle while halted.
        apply(0, 16'h0, 0, 0, 1, 16'h0003, 16'h0, 0);
        step();
        idle();
        step();
        check_all("ded3_halt", 16'hA8CC, 0, 0, 4'h0, 1, 1, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        check_all("reset_in_halt", 16'h0, 1, 0, 4'h0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Randomized run against the model.
        for (int n = 0; n < 2500; n++) begin
            r_ld  = ($urandom_range(19) == 0);
            r_lv  = 16'($urandom);
            r_en  = ($urandom_range(3) != 0);
            r_up  = ($urandom_range(1) == 1);
            r_clr = ($urandom_range(24) == 0);
            r_inj = ($urandom_range(99) < 15);
            gen_masks(r_dm, r_cm);
            if (r_inj && !m_halt) begin
                ok = 1'b1;
                for (int b = 0; b < 4; b++) begin
                    if (blk_pop(m_df ^ r_dm, m_cf ^ r_cm, b) > 2) ok = 1'b0;
                end
                r_inj = ok;
            end
            if (!r_inj) begin
                r_dm = '0;
                r_cm = '0;
            end
            apply(r_ld, r_lv, r_en, r_up, r_inj, r_dm, r_cm, r_clr);
            model_step(r_ld, r_lv, r_en, r_up, r_inj, r_dm, r_cm, r_clr);
            step();
            check_all($sformatf("rnd%0d", n), m_gold ^ m_df,
                      !m_halt && (m_df == 16'h0) && (m_cf == 16'h0), m_sec, m_blk, m_ded,
                      m_halt, m_c8, m_c2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
